// File: rtl/collision_requester.sv
// Collision search requester: loads a message, arms the search, polls the search status
// and fetches collision and digest counts over a custom-instruction bus, guarded by a watchdog.
module collision_requester #(
  parameter int unsigned POLL_GAP     = 16,
  parameter int unsigned MAX_POLLS    = 1024,
  parameter int unsigned DONE_TIMEOUT = 256
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_go,
  input  logic [511:0] i_message,
  input  logic [4:0]   i_target,
  output logic         o_ci_start,
  output logic [2:0]   o_ci_n,
  output logic [31:0]  o_ci_dataa,
  output logic [31:0]  o_ci_datab,
  input  logic         i_ci_done,
  input  logic [31:0]  i_ci_result,
  output logic         o_busy,
  output logic         o_job_done,
  output logic         o_found,
  output logic [31:0]  o_collision,
  output logic [31:0]  o_digests,
  output logic [1:0]   o_error
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOAD      = 3'd1;
  localparam logic [2:0] S_ARM       = 3'd2;
  localparam logic [2:0] S_GAP       = 3'd3;
  localparam logic [2:0] S_POLL      = 3'd4;
  localparam logic [2:0] S_FETCH_RES = 3'd5;
  localparam logic [2:0] S_FETCH_DIG = 3'd6;
  localparam logic [2:0] S_FINISH    = 3'd7;

  localparam logic [15:0] GAP_LAST  = 16'(POLL_GAP - 1);
  localparam logic [15:0] WD_LAST   = 16'(DONE_TIMEOUT - 1);
  localparam logic [31:0] POLL_LAST = 32'(MAX_POLLS - 1);

  logic [2:0]   r_state;
  logic [511:0] r_msg;
  logic [4:0]   r_target;
  logic [2:0]   r_k;
  logic         r_out;
  logic [15:0]  r_gap;
  logic [31:0]  r_polls;
  logic [15:0]  r_wd;

  logic [7:0][63:0] w_pairs;
  logic [63:0]      w_pair;
  logic             w_done;
  logic             w_wd_expired;
  logic             w_issue;
  logic [2:0]       w_n;
  logic [31:0]      w_a;
  logic [31:0]      w_b;

  // Next-transaction operands and handshake qualifiers; pair 0 sits in the top 64 message bits
  always_comb begin
    w_pairs      = r_msg;
    w_pair       = w_pairs[3'd7 - r_k];
    w_done       = r_out & i_ci_done;
    w_wd_expired = r_out & ~i_ci_done & (r_wd == WD_LAST);
    w_issue      = 1'b0;
    w_n          = 3'd3;
    w_a          = 32'd0;
    w_b          = 32'd0;
    case (r_state)
      S_LOAD: begin
        w_issue = ~r_out;
        w_n     = 3'd0;
        w_a     = w_pair[63:32];
        w_b     = w_pair[31:0];
      end
      S_ARM: begin
        w_issue = ~r_out;
        w_n     = 3'd1;
        w_a     = {27'd0, r_target};
      end
      S_GAP:       w_issue = (r_gap == GAP_LAST);
      S_FETCH_RES: begin
        w_issue = ~r_out;
        w_n     = 3'd2;
      end
      S_FETCH_DIG: begin
        w_issue = ~r_out;
        w_n     = 3'd4;
      end
      default:     w_issue = 1'b0;
    endcase
  end

  // Job sequencer, transaction issue/tracking and watchdog
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_msg       <= 512'd0;
      r_target    <= 5'd0;
      r_k         <= 3'd0;
      r_out       <= 1'b0;
      r_gap       <= 16'd0;
      r_polls     <= 32'd0;
      r_wd        <= 16'd0;
      o_ci_start  <= 1'b0;
      o_ci_n      <= 3'd0;
      o_ci_dataa  <= 32'd0;
      o_ci_datab  <= 32'd0;
      o_busy      <= 1'b0;
      o_job_done  <= 1'b0;
      o_found     <= 1'b0;
      o_collision <= 32'd0;
      o_digests   <= 32'd0;
      o_error     <= 2'b00;
    end else begin
      o_ci_start <= 1'b0;
      o_job_done <= 1'b0;
      if (w_issue) begin
        o_ci_start <= 1'b1;
        o_ci_n     <= w_n;
        o_ci_dataa <= w_a;
        o_ci_datab <= w_b;
        r_out      <= 1'b1;
        r_wd       <= 16'd0;
      end else if (r_out) begin
        if (i_ci_done || w_wd_expired) begin
          r_out <= 1'b0;
          r_wd  <= 16'd0;
        end else begin
          r_wd <= r_wd + 16'd1;
        end
      end
      if (w_wd_expired) begin
        o_error    <= 2'b10;
        o_found    <= 1'b0;
        o_busy     <= 1'b0;
        o_job_done <= 1'b1;
        r_state    <= S_FINISH;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_go) begin
              r_msg       <= i_message;
              r_target    <= i_target;
              r_k         <= 3'd0;
              o_found     <= 1'b0;
              o_collision <= 32'd0;
              o_error     <= 2'b00;
              o_busy      <= 1'b1;
              o_ci_start  <= 1'b1;
              o_ci_n      <= 3'd0;
              o_ci_dataa  <= i_message[511:480];
              o_ci_datab  <= i_message[479:448];
              r_out       <= 1'b1;
              r_wd        <= 16'd0;
              r_state     <= S_LOAD;
            end
          end
          S_LOAD: begin
            if (w_done) begin
              if (r_k == 3'd7) r_state <= S_ARM;
              else r_k <= r_k + 3'd1;
            end
          end
          S_ARM: begin
            if (w_done) begin
              r_gap   <= 16'd0;
              r_polls <= 32'd0;
              r_state <= S_GAP;
            end
          end
          // The poll strobe is launched from the last gap cycle so polls are POLL_GAP+1 apart
          S_GAP: begin
            if (r_gap == GAP_LAST) r_state <= S_POLL;
            else r_gap <= r_gap + 16'd1;
          end
          S_POLL: begin
            if (w_done) begin
              if (i_ci_result[0]) begin
                r_state <= S_FETCH_RES;
              end else if (r_polls == POLL_LAST) begin
                r_polls <= r_polls + 32'd1;
                o_error <= 2'b01;
                r_state <= S_FETCH_DIG;
              end else begin
                r_polls <= r_polls + 32'd1;
                r_gap   <= 16'd0;
                r_state <= S_GAP;
              end
            end
          end
          S_FETCH_RES: begin
            if (w_done) begin
              o_collision <= i_ci_result;
              o_found     <= 1'b1;
              r_state     <= S_FETCH_DIG;
            end
          end
          S_FETCH_DIG: begin
            if (w_done) begin
              o_digests  <= i_ci_result;
              o_busy     <= 1'b0;
              o_job_done <= 1'b1;
              r_state    <= S_FINISH;
            end
          end
          S_FINISH: r_state <= S_IDLE;
          default:  r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_collision_requester.sv
// Self-checking bench for collision_requester: scripted responder plus a job-level model
// giving the expected strobe list, strobe times and final job outputs.
module tb_collision_requester;

  localparam int G    = 16;
  localparam int MAXP = 4;
  localparam int WDT  = 256;
  localparam int LOGN = 1024;

  logic         clk     = 1'b0;
  logic         rst_n   = 1'b0;
  logic         go      = 1'b0;
  logic [511:0] message = '0;
  logic [4:0]   target  = '0;
  logic         ci_start;
  logic [2:0]   ci_n;
  logic [31:0]  ci_dataa, ci_datab;
  logic         ci_done;
  logic [31:0]  ci_result;
  logic         busy, job_done, found;
  logic [31:0]  collision, digests;
  logic [1:0]   error;

  int          resp_delay  = 0;
  bit          resp_silent = 1'b0;
  int          resp_fpoll  = 0;
  logic [31:0] resp_coll   = '0;
  logic [31:0] resp_dig    = '0;
  logic [31:0] resp_noise  = '0;
  logic        r_pend  = 1'b0;
  int          r_cnt   = 0;
  int          r_polls = 0;

  int          cyc     = 0;
  int          log_cnt = 0;
  int          viol    = 0;
  int          jd_cnt  = 0;
  int          log_cyc [LOGN];
  logic [2:0]  log_n   [LOGN];
  logic [31:0] log_a   [LOGN];
  logic [31:0] log_b   [LOGN];
  logic        prev_start = 1'b0;
  logic        outst      = 1'b0;
  logic [2:0]  h_n = '0;
  logic [31:0] h_a = '0, h_b = '0;

  int          checks  = 0;
  int          errors  = 0;
  logic [31:0] exp_dig = '0;

  collision_requester #(.POLL_GAP(G), .MAX_POLLS(MAXP), .DONE_TIMEOUT(WDT)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_go(go), .i_message(message), .i_target(target),
    .o_ci_start(ci_start), .o_ci_n(ci_n), .o_ci_dataa(ci_dataa), .o_ci_datab(ci_datab),
    .i_ci_done(ci_done), .i_ci_result(ci_result), .o_busy(busy), .o_job_done(job_done),
    .o_found(found), .o_collision(collision), .o_digests(digests), .o_error(error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Responder: zero-wait, fixed delay or silent; reports found on poll number resp_fpoll
  always_comb begin
    if (resp_silent) ci_done = 1'b0;
    else if (resp_delay == 0) ci_done = ci_start;
    else ci_done = r_pend && (r_cnt == resp_delay);
  end

  always_comb begin
    case (ci_n)
      3'd2:    ci_result = resp_coll;
      3'd3:    ci_result = {resp_noise[31:1], ((r_polls + 1) == resp_fpoll) ? 1'b1 : 1'b0};
      3'd4:    ci_result = resp_dig;
      default: ci_result = resp_noise;
    endcase
  end

  always @(posedge clk) begin
    if (ci_start && !ci_done) begin
      r_pend <= 1'b1;
      r_cnt  <= 1;
    end else if (r_pend) begin
      if (ci_done) r_pend <= 1'b0;
      else r_cnt <= r_cnt + 1;
    end
    if (ci_start && ci_n == 3'd1) r_polls <= 0;
    else if (ci_done && ci_n == 3'd3) r_polls <= r_polls + 1;
  end

  // Monitor: strobe log, protocol violations (back-to-back strobes, operand changes), job_done pulses
  always @(negedge clk) begin
    if (ci_start) begin
      if (log_cnt < LOGN) begin
        log_cyc[log_cnt] <= cyc;
        log_n[log_cnt]   <= ci_n;
        log_a[log_cnt]   <= ci_dataa;
        log_b[log_cnt]   <= ci_datab;
      end
      log_cnt <= log_cnt + 1;
    end
    prev_start <= ci_start;
    viol <= viol + ((ci_start && prev_start) ? 1 : 0)
                 + ((!ci_start && outst && (ci_n != h_n || ci_dataa != h_a || ci_datab != h_b)) ? 1 : 0);
    if (!rst_n) begin
      outst <= 1'b0;
    end else if (ci_start) begin
      h_n   <= ci_n;
      h_a   <= ci_dataa;
      h_b   <= ci_datab;
      outst <= !ci_done;
    end else if (outst && ci_done) begin
      outst <= 1'b0;
    end
    if (job_done) jd_cnt <= jd_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [511:0] rand_msg();
    logic [511:0] m;
    for (int w = 0; w < 16; w++) m[32*w +: 32] = $urandom;
    return m;
  endfunction

  // One full job; go_at: -1 none, -2 extra go in the FINISH cycle, -3 extra go in the first POLL cycle, else that cycle
  task automatic do_job(input logic [511:0] m, input logic [4:0] t, input int delay, input int fpoll,
                        input logic [31:0] coll, input logic [31:0] dig, input int go_at);
    int n_exp [16];
    logic [31:0] a_exp [16];
    logic [31:0] b_exp [16];
    int t_exp [16];
    int cnt, polls, base, g0, jd0, v0, jd_rel, jd_seen, eff;
    bit is_found;
    is_found = (fpoll >= 1 && fpoll <= MAXP);
    polls = is_found ? fpoll : MAXP;
    for (int k = 0; k < 8; k++) begin
      n_exp[k] = 0;
      a_exp[k] = m[511-64*k -: 32];
      b_exp[k] = m[479-64*k -: 32];
    end
    n_exp[8] = 1; a_exp[8] = {27'd0, t}; b_exp[8] = 32'd0;
    cnt = 9;
    for (int p = 0; p < polls; p++) begin
      n_exp[cnt] = 3; a_exp[cnt] = 32'd0; b_exp[cnt] = 32'd0; cnt++;
    end
    if (is_found) begin
      n_exp[cnt] = 2; a_exp[cnt] = 32'd0; b_exp[cnt] = 32'd0; cnt++;
    end
    n_exp[cnt] = 4; a_exp[cnt] = 32'd0; b_exp[cnt] = 32'd0; cnt++;
    t_exp[0] = 1;
    for (int k = 1; k < cnt; k++) t_exp[k] = t_exp[k-1] + delay + ((n_exp[k] == 3) ? G + 1 : 2);
    jd_rel = t_exp[cnt-1] + delay + 1;
    eff = (go_at == -2) ? jd_rel : ((go_at == -3) ? t_exp[9] : go_at);

    resp_delay = delay; resp_fpoll = fpoll; resp_coll = coll; resp_dig = dig; resp_noise = $urandom;
    @(negedge clk);
    message = m; target = t; go = 1'b1;
    g0 = cyc; base = log_cnt; jd0 = jd_cnt; v0 = viol; jd_seen = -1;
    for (int rel = 1; rel <= jd_rel + 6; rel++) begin
      @(negedge clk);
      go = 1'b0;
      if (rel == eff) begin
        go = 1'b1; message = ~m; target = ~t;
      end
      if (rel == 1) begin
        chk("busy_after_go", 64'(busy), 64'd1);
        chk("cleared_on_go", {collision, 29'd0, found, error}, 64'd0);
        chk("digests_kept", 64'(digests), 64'(exp_dig));
      end
      if (job_done === 1'b1 && jd_seen < 0) begin
        jd_seen = rel;
        chk("busy_low_at_done", 64'(busy), 64'd0);
      end
    end
    chk("job_done_cycle", 64'(jd_seen), 64'(jd_rel));
    chk("job_done_pulses", 64'(jd_cnt - jd0), 64'd1);
    chk("strobe_count", 64'(log_cnt - base), 64'(cnt));
    for (int k = 0; k < cnt; k++) begin
      if (base + k < LOGN) begin
        chk($sformatf("strobe%0d_n", k), 64'(log_n[base+k]), 64'(n_exp[k]));
        chk($sformatf("strobe%0d_ops", k), {log_a[base+k], log_b[base+k]}, {a_exp[k], b_exp[k]});
        chk($sformatf("strobe%0d_time", k), 64'(log_cyc[base+k] - g0), 64'(t_exp[k]));
      end
    end
    chk("found", 64'(found), 64'(is_found));
    chk("collision", 64'(collision), is_found ? 64'(coll) : 64'd0);
    chk("digests", 64'(digests), 64'(dig));
    chk("error", 64'(error), is_found ? 64'd0 : 64'd1);
    chk("protocol_viol", 64'(viol - v0), 64'd0);
    chk("busy_idle", 64'(busy), 64'd0);
    exp_dig = dig;
  endtask

  initial begin
    logic [511:0] m;
    int base, jd0, jd_seen, g0;

    repeat (3) @(negedge clk);
    chk("reset_ctrl", {ci_start, ci_n, busy, job_done, found, error}, 64'd0);
    chk("reset_ops", {ci_dataa, ci_datab}, 64'd0);
    chk("reset_res", {collision, digests}, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Zero-wait responder, patterned message, found on the 3rd poll
    for (int w = 0; w < 16; w++) m[511-32*w -: 32] = 32'h0001_0000 + 32'(w);
    do_job(m, 5'd3, 0, 3, 32'h0000_1A2B, 32'd5000, -1);

    // Never found: MAX_POLLS polls then digest fetch with poll timeout
    do_job(rand_msg(), 5'($urandom_range(0, 31)), 0, 0, $urandom, $urandom, -1);

    // Slow responder: operands held through a 5-cycle wait
    do_job(rand_msg(), 5'($urandom_range(0, 31)), 5, 2, $urandom, $urandom, -1);

    // Silent responder: watchdog ends the job with error 10
    resp_silent = 1'b1;
    @(negedge clk);
    message = rand_msg(); go = 1'b1;
    g0 = cyc; base = log_cnt; jd0 = jd_cnt; jd_seen = -1;
    for (int rel = 1; rel <= WDT + 8; rel++) begin
      @(negedge clk);
      go = 1'b0;
      if (job_done === 1'b1 && jd_seen < 0) begin
        jd_seen = rel;
        chk("wd_busy_at_done", 64'(busy), 64'd0);
      end
    end
    chk("wd_done_window", 64'(jd_seen >= WDT + 1 && jd_seen <= WDT + 2), 64'd1);
    chk("wd_strobes", 64'(log_cnt - base), 64'd1);
    chk("wd_pulses", 64'(jd_cnt - jd0), 64'd1);
    chk("wd_error", {29'd0, found, error, busy}, {29'd0, 1'b0, 2'b10, 1'b0});
    chk("wd_digests_kept", 64'(digests), 64'(exp_dig));
    resp_silent = 1'b0;

    do_job(rand_msg(), 5'($urandom_range(0, 31)), 1, 1, $urandom, $urandom, -1);

    // Reset during LOAD k=4 abandons the job with no job_done
    m = rand_msg(); resp_delay = 0;
    @(negedge clk);
    message = m; go = 1'b1; g0 = cyc; jd0 = jd_cnt;
    for (int rel = 1; rel <= 9; rel++) begin
      @(negedge clk);
      go = 1'b0;
    end
    chk("k4_strobe", {ci_start, ci_n, ci_dataa}, {28'd0, 1'b1, 3'd0, m[255:224]});
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_ctrl", {ci_start, ci_n, busy, job_done, found, error}, 64'd0);
    chk("midrst_ops", {ci_dataa, ci_datab}, 64'd0);
    chk("midrst_res", {collision, digests}, 64'd0);
    exp_dig = 32'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    base = log_cnt;
    repeat (4) @(negedge clk);
    chk("midrst_no_done", 64'(jd_cnt - jd0), 64'd0);
    chk("midrst_no_strobe", 64'(log_cnt - base), 64'd0);
    do_job(rand_msg(), 5'($urandom_range(0, 31)), 0, 2, $urandom, $urandom, -1);

    // Go during POLL and go in the FINISH cycle are both ignored
    do_job(rand_msg(), 5'($urandom_range(0, 31)), 0, 2, $urandom, $urandom, -3);
    do_job(rand_msg(), 5'($urandom_range(0, 31)), 2, 1, $urandom, $urandom, -2);

    // Randomized jobs, some with a go pulse while busy in LOAD
    for (int j = 0; j < 6; j++)
      do_job(rand_msg(), 5'($urandom_range(0, 31)), $urandom_range(0, 4), $urandom_range(0, 5),
             $urandom, $urandom, ($urandom_range(0, 1) == 1) ? 4 : -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/collision_requester.md
COLLISION_REQUESTER -- requirements
Module: collision_requester

Interface
REQ-001 Parameter POLL_GAP, default 16: cycles from one transaction's completion to the next status poll (n=3); legal range 1..65535.
REQ-002 Parameter MAX_POLLS, default 1024: number of status polls before the search is abandoned with a timeout.
REQ-003 Parameter DONE_TIMEOUT, default 256: cycles to wait for ci_done before declaring a bus error.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 go  in  1  one-cycle request to run a full search job; sampled only in IDLE.
REQ-007 message  in  512  base message; sampled in full on the cycle go is accepted.
REQ-008 target  in  5  collision target; sampled on the cycle go is accepted.
REQ-009 ci_start  out  1  custom-instruction start strobe.
REQ-010 ci_n  out  3  instruction select.
REQ-011 ci_dataa  out  32  instruction operand A.
REQ-012 ci_datab  out  32  instruction operand B.
REQ-013 ci_done  in  1  instruction completion; may be asserted in the same cycle as ci_start.
REQ-014 ci_result  in  32  instruction result; valid when ci_done=1.
REQ-015 busy  out  1  high from go acceptance until job_done.
REQ-016 job_done  out  1  one-cycle pulse at job end.
REQ-017 found  out  1  the job ended with a collision.
REQ-018 collision  out  32  counter value of the collision.
REQ-019 digests  out  32  total digest count read at job end.
REQ-020 error  out  2  00 ok, 01 poll timeout, 10 ci_done timeout.

Function
REQ-021 States: IDLE, LOAD, ARM, GAP, POLL, FETCH_RES, FETCH_DIG, FINISH. Each non-IDLE/GAP/FINISH state issues one transaction.
REQ-022 Transaction rules: ci_start=1 for exactly one cycle; ci_n/ci_dataa/ci_datab held stable from the ci_start cycle until the ci_done cycle inclusive; ci_result captured in the ci_done cycle; ci_start is never high in two consecutive cycles; ci_done while no transaction is outstanding is ignored.
REQ-023 LOAD: 8 transactions, n=0, pair k=0..7 uses dataa=message[511-64k -: 32], datab=message[479-64k -: 32]; k=0 is issued the cycle after go is accepted.
REQ-024 ARM: one transaction, n=1, dataa={27'd0,target}, datab=0; issued the cycle after the LOAD k=7 done.
REQ-025 GAP: wait POLL_GAP cycles, then POLL: n=3, operands 0; result bit0=1 -> FETCH_RES; result bit0=0 -> increment the poll count and return to GAP, or go to FETCH_DIG with error=01 once the count reaches MAX_POLLS.
REQ-026 FETCH_RES: n=2, captured result -> collision, found=1. FETCH_DIG: n=4, captured result -> digests. FINISH: job_done=1 and busy=0 in the same cycle, then IDLE.
REQ-027 Watchdog: if ci_done does not arrive within DONE_TIMEOUT cycles after ci_start, drop the transaction, set error=10, found=0, go to FINISH, and skip all remaining transactions.
REQ-028 On go acceptance: found, collision and error are cleared; digests keeps its previous value until FETCH_DIG completes.
REQ-029 go while busy=1 is ignored with no side effects; go in the FINISH cycle is ignored.
REQ-030 Counter widths: 16-bit poll gap counter, 32-bit poll count, 16-bit watchdog counter; none wraps.
REQ-031 Zero-wait responder (ci_done=ci_start): go at cycle 0, LOAD strobes at cycles 1,3,...,15, ARM strobe at cycle 17.

Reset
REQ-032 reset=0 forces IDLE immediately, regardless of the clock; ci_start, ci_n, ci_dataa, ci_datab, busy, job_done, found, collision, digests and error all read 0.
REQ-033 reset asserted mid-transaction abandons the job; no job_done pulse is produced, and the first go after release starts a fresh job from LOAD k=0.

Verification
REQ-034 Zero-wait responder, message=512'h0001..., target=5'd3, go -> LOAD operands match REQ-023 word order, ARM strobe at cycle 17 with dataa=32'd3.
REQ-035 Responder reports found on the 3rd poll, with collision result 32'h0000_1A2B and digest result 32'd5000 -> found=1, collision=32'h0000_1A2B, digests=32'd5000, error=00, a single job_done pulse, and exactly 3 n=3 strobes spaced POLL_GAP+1 cycles apart.
REQ-036 MAX_POLLS=4, responder never reports found -> 4 polls, then an n=4 fetch, found=0, error=01, and no n=2 strobe.
REQ-037 Responder delays ci_done by 5 cycles -> operands held stable for 6 cycles and no second strobe in that window; with the responder silent for 256 cycles -> error=10 and job_done follows.
REQ-038 reset pulsed during LOAD k=4 -> all outputs 0 immediately; next go -> first strobe carries pair k=0.
REQ-039 go pulsed during POLL -> ignored; the job completes normally, with one job_done pulse only.
